// File: rtl/music_sequencer.sv
// Control unit for song_reader: turns play/next/prev pulses and song_done into
// play, song and reset_player, with track stepping, auto-advance and optional loop.
module music_sequencer #(
   parameter int NUM_SONGS = 4,
   parameter int SONG_W    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play_button,
   input  logic              next_button,
   input  logic              prev_button,
   input  logic              loop_en,
   input  logic              song_done,
   output logic              play,
   output logic [SONG_W-1:0] song,
   output logic              reset_player
);

   typedef enum logic [1:0] {
      PAUSED  = 2'd0,
      PLAYING = 2'd1,
      ADVANCE = 2'd2
   } state_t;

   localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

   state_t            state, next_state;
   logic              resume, next_resume;
   logic [SONG_W-1:0] next_song;
   logic [SONG_W-1:0] song_inc, song_dec;
   logic              skip;

   assign song_inc = (song == LAST_SONG) ? '0 : song + SONG_W'(1);
   assign song_dec = (song == '0) ? LAST_SONG : song - SONG_W'(1);
   assign skip     = next_button ^ prev_button;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= PAUSED;
         resume <= 1'b0;
         song   <= '0;
      end else begin
         state  <= next_state;
         resume <= next_resume;
         song   <= next_song;
      end
   end

   // Skips win over song_done, which wins over play_button; losers are dropped.
   always_comb begin
      next_state  = state;
      next_resume = resume;
      next_song   = song;
      case (state)
         PAUSED: begin
            if (skip) begin
               next_state  = ADVANCE;
               next_resume = 1'b0;
               next_song   = next_button ? song_inc : song_dec;
            end else if (play_button) begin
               next_state = PLAYING;
            end
         end
         PLAYING: begin
            if (skip) begin
               next_state  = ADVANCE;
               next_resume = 1'b1;
               next_song   = next_button ? song_inc : song_dec;
            end else if (song_done) begin
               next_state = ADVANCE;
               next_song  = song_inc;
               // Running off the end without looping parks on song 0, paused.
               next_resume = !((song == LAST_SONG) && !loop_en);
            end else if (play_button) begin
               next_state = PAUSED;
            end
         end
         ADVANCE: begin
            next_state = resume ? PLAYING : PAUSED;
         end
         default: begin
            next_state = PAUSED;
         end
      endcase
   end

   assign play         = (state == PLAYING);
   assign reset_player = (state == ADVANCE);

endmodule

// File: tb/tb_music_sequencer.sv
// Directed self-checking bench for music_sequencer with hand-computed expectations.
module tb_music_sequencer;

   logic       clk;
   logic       reset;
   logic       play_button;
   logic       next_button;
   logic       prev_button;
   logic       loop_en;
   logic       song_done;
   logic       play;
   logic [1:0] song;
   logic       reset_player;

   int errors;
   int checks;

   music_sequencer #(
      .NUM_SONGS(4),
      .SONG_W(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .play_button(play_button),
      .next_button(next_button),
      .prev_button(prev_button),
      .loop_en(loop_en),
      .song_done(song_done),
      .play(play),
      .song(song),
      .reset_player(reset_player)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic exp_play, input logic [1:0] exp_song,
                           input logic exp_rp);
      checkOutput({tag, ".play"}, {7'd0, play}, {7'd0, exp_play});
      checkOutput({tag, ".song"}, {6'd0, song}, {6'd0, exp_song});
      checkOutput({tag, ".reset_player"}, {7'd0, reset_player}, {7'd0, exp_rp});
   endtask

   // Present one cycle of button pulses across a rising edge, sampled 1ns after it.
   task automatic applyStimulus(input logic pb, input logic nb, input logic vb);
      play_button = pb;
      next_button = nb;
      prev_button = vb;
      @(posedge clk);
      #1;
      play_button = 1'b0;
      next_button = 1'b0;
      prev_button = 1'b0;
   endtask

   initial begin
      errors      = 0;
      checks      = 0;
      reset       = 1'b1;
      play_button = 1'b0;
      next_button = 1'b0;
      prev_button = 1'b0;
      loop_en     = 1'b0;
      song_done   = 1'b0;

      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      checkAll("reset", 0, 2'd0, 0);
      reset = 1'b0;
      applyStimulus(0, 0, 0);
      checkAll("idle", 0, 2'd0, 0);

      // play toggles
      applyStimulus(1, 0, 0);
      checkAll("play_on", 1, 2'd0, 0);
      applyStimulus(1, 0, 0);
      checkAll("play_off", 0, 2'd0, 0);

      // prev from song 0 while paused wraps to 3
      applyStimulus(0, 0, 1);
      checkAll("prev_wrap_adv", 0, 2'd3, 1);
      applyStimulus(0, 0, 0);
      checkAll("prev_wrap_paused", 0, 2'd3, 0);
      applyStimulus(0, 1, 1);
      checkAll("next_prev_cancel", 0, 2'd3, 0);

      // song_done ignored while paused
      song_done = 1'b1;
      applyStimulus(0, 0, 0);
      checkAll("paused_done_ignored", 0, 2'd3, 0);
      song_done = 1'b0;

      // next from 3 wraps to 0, then to 1
      applyStimulus(0, 1, 0);
      checkAll("next_wrap_adv", 0, 2'd0, 1);
      applyStimulus(0, 1, 0);
      checkAll("adv_ignores_next", 0, 2'd0, 0);
      applyStimulus(0, 1, 0);
      checkAll("next_to_1", 0, 2'd1, 1);
      applyStimulus(0, 0, 0);

      // playing song 1, next -> song 2 with one-cycle restart
      applyStimulus(1, 0, 0);
      checkAll("play_s1", 1, 2'd1, 0);
      applyStimulus(0, 1, 0);
      checkAll("play_next_adv", 0, 2'd2, 1);
      applyStimulus(0, 0, 0);
      checkAll("play_next_resume", 1, 2'd2, 0);

      // cancelled skip lets play_button through
      applyStimulus(1, 1, 1);
      checkAll("cancel_then_pause", 0, 2'd2, 0);
      applyStimulus(1, 0, 0);
      checkAll("replay_s2", 1, 2'd2, 0);

      // auto-advance past last song with loop
      applyStimulus(0, 1, 0);
      applyStimulus(0, 0, 0);
      checkAll("play_s3", 1, 2'd3, 0);
      loop_en   = 1'b1;
      song_done = 1'b1;
      applyStimulus(0, 0, 0);
      checkAll("loop_adv", 0, 2'd0, 1);
      applyStimulus(0, 0, 0);
      checkAll("loop_resume", 1, 2'd0, 0);
      song_done = 1'b0;
      applyStimulus(0, 0, 0);
      checkAll("loop_single_pulse", 1, 2'd0, 0);

      // auto-advance past last song without loop stops on song 0
      applyStimulus(0, 0, 1);
      applyStimulus(0, 0, 0);
      checkAll("play_s3_again", 1, 2'd3, 0);
      loop_en   = 1'b0;
      song_done = 1'b1;
      applyStimulus(0, 0, 0);
      checkAll("noloop_adv", 0, 2'd0, 1);
      applyStimulus(0, 0, 0);
      checkAll("noloop_paused", 0, 2'd0, 0);
      song_done = 1'b0;
      applyStimulus(0, 0, 0);
      checkAll("noloop_stays", 0, 2'd0, 0);

      // song_done and play_button together: play_button dropped
      applyStimulus(1, 0, 0);
      checkAll("play_s0", 1, 2'd0, 0);
      song_done = 1'b1;
      applyStimulus(1, 0, 0);
      checkAll("done_play_adv", 0, 2'd1, 1);
      song_done = 1'b0;
      applyStimulus(0, 0, 0);
      checkAll("done_play_resume", 1, 2'd1, 0);
      applyStimulus(0, 0, 0);
      checkAll("done_play_still", 1, 2'd1, 0);

      // async reset in the middle of ADVANCE, no clock edge
      applyStimulus(0, 1, 0);
      checkAll("pre_reset_adv", 0, 2'd2, 1);
      #2;
      reset = 1'b1;
      #1;
      checkAll("async_reset", 0, 2'd0, 0);
      applyStimulus(0, 0, 0);
      reset = 1'b0;
      applyStimulus(0, 0, 0);
      checkAll("post_reset", 0, 2'd0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
